ifetch_unit: RTL and testbench
==============================

IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, SHALL be the first fetch address after reset.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 npc  input  32  SHALL carry the next-instruction address from the NPC unit.
REQ-005 npc_valid  input  1  SHALL indicate the core has consumed the current instruction and npc is final.
REQ-006 imem_req  output  1  SHALL request an instruction-memory read.
REQ-007 imem_addr  output  32  SHALL carry the fetch address.
REQ-008 imem_gnt  input  1  SHALL indicate the memory accepted the request this cycle.
REQ-009 imem_rvalid  input  1  SHALL indicate imem_rdata is valid this cycle.
REQ-010 imem_rdata  input  32  SHALL carry the fetched instruction word.
REQ-011 pc  output  32  SHALL expose the address of the instruction being fetched or held.
REQ-012 instr  output  32  SHALL expose the fetched instruction.
REQ-013 instr_valid  output  1  SHALL indicate instr and pc are valid for decode.
REQ-014 misalign_err  output  1  SHALL flag a misaligned npc (see Configuration).

Function
REQ-015 The FSM SHALL have states REQ_S, WAIT_S, VALID_S and ERR_S.
REQ-016 In REQ_S: imem_req=1, imem_addr=pc; on imem_gnt=1 the FSM SHALL move to WAIT_S next cycle.
REQ-017 In WAIT_S: imem_req=0; on imem_rvalid=1, instr SHALL load imem_rdata and the FSM SHALL move to VALID_S, so instr_valid rises the cycle after imem_rvalid.
REQ-018 In VALID_S: instr_valid=1, instr and pc SHALL be held stable until npc_valid=1.
REQ-019 In VALID_S with npc_valid=1: pc SHALL load npc, the FSM SHALL move to REQ_S, instr_valid SHALL drop next cycle, and imem_req SHALL assert with the new address that same next cycle.
REQ-020 npc_valid in any state other than VALID_S SHALL be ignored.
REQ-021 imem_rvalid in any state other than WAIT_S SHALL be discarded; rvalid in the same cycle as gnt SHALL not be accepted (earliest is gnt+1).
REQ-022 npc SHALL be taken unmodified as 32 bits, with no addition or bit clearing; the address space wraps modulo 2^32.
REQ-023 Minimum fetch latency, npc_valid to next instr_valid, SHALL be 3 cycles with gnt in the first REQ_S cycle and rvalid one cycle later.
REQ-024 ERR_S SHALL hold imem_req=0, instr_valid=0 and misalign_err=1 until reset.

Reset
REQ-025 While rst=1, the module SHALL set pc=RESET_PC, instr=0, instr_valid=0, misalign_err=0 and imem_req=0; the state SHALL be REQ_S on the first cycle after release.
REQ-026 rst in WAIT_S SHALL abandon the outstanding request; the memory is reset by the same rst, so no stale rvalid follows.

Configuration
REQ-027 With IFETCH_MISALIGN_CHECK_EN defined, npc_valid=1 in VALID_S with npc[1:0]!=0 SHALL leave pc unchanged and enter ERR_S next cycle.
REQ-028 Without IFETCH_MISALIGN_CHECK_EN, misalign_err SHALL be tied 0, ERR_S SHALL be unreachable, and misaligned npc SHALL be issued unchanged.

Structure
REQ-029 The state encoding, the RESET_PC default and the 32-bit address width constant SHALL live in shared package ifetch_pkg.
REQ-030 The block SHALL be a single module with no sub-modules.

Verification
REQ-031 Release rst, gnt on the first cycle, rvalid next with rdata=32'h0000_0013 -> imem_addr=0x0; instr_valid=1 with instr=0x13, pc=0x0 two cycles after gnt.
REQ-032 In VALID_S apply npc=0x0000_0010 with npc_valid=1 -> next cycle instr_valid=0, imem_req=1, imem_addr=0x10, pc=0x10.
REQ-033 Hold gnt=0 for 4 cycles, then rvalid 3 cycles after gnt -> imem_req stays 1 with a stable address; rvalid before gnt and in the gnt cycle are discarded; instr_valid rises exactly one cycle after the accepted rvalid.
REQ-034 Assert rst in WAIT_S -> next cycle pc=RESET_PC, instr_valid=0; after release a fresh request to RESET_PC.
REQ-035 With IFETCH_MISALIGN_CHECK_EN, npc=0x0000_0006 with npc_valid -> misalign_err=1, pc unchanged, no further imem_req until rst; without the macro -> imem_addr=0x6.
REQ-036 npc=0xFFFF_FFFC then a fetch completes -> pc=0xFFFF_FFFC and imem_addr=0xFFFF_FFFC issued with no overflow side effects.

Source files
------------

// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit: address width,
// default reset PC, FSM state encoding and an alignment helper.
package ifetch_pkg;

    localparam int unsigned ADDR_W = 32'd32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        REQ_S   = 2'd0,
        WAIT_S  = 2'd1,
        VALID_S = 2'd2,
        ERR_S   = 2'd3
    } fetch_state_e;

    // Word alignment: the two low address bits must be zero.
    function automatic logic is_word_aligned(input logic [ADDR_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage

// File: rtl/ifetch_unit.sv
// Instruction fetch unit: issues one instruction-memory read at a time,
// captures the returned word and holds it for decode until the core
// supplies the next PC.
// Optional feature macro: IFETCH_MISALIGN_CHECK_EN -- when defined, a
// misaligned next PC parks the unit in ERR_S (misalign_err=1) until reset;
// when undefined the misaligned address is fetched as-is.
module ifetch_unit
    import ifetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] npc,
    input  logic              npc_valid,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [ADDR_W-1:0] pc,
    output logic [31:0]       instr,
    output logic              instr_valid,
    output logic              misalign_err
);

    fetch_state_e      state_r;
    fetch_state_e      state_nxt_s;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pc_nxt_s;
    logic [31:0]       instr_r;
    logic [31:0]       instr_nxt_s;

    // Next-state, next-PC and instruction-capture decisions.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        instr_nxt_s = instr_r;
        case (state_r)
            REQ_S: begin
                // rvalid here belongs to no accepted request and is dropped.
                if (imem_gnt) begin
                    state_nxt_s = WAIT_S;
                end else begin
                    state_nxt_s = REQ_S;
                end
            end
            WAIT_S: begin
                if (imem_rvalid) begin
                    instr_nxt_s = imem_rdata;
                    state_nxt_s = VALID_S;
                end else begin
                    state_nxt_s = WAIT_S;
                end
            end
            VALID_S: begin
                if (npc_valid) begin
`ifdef IFETCH_MISALIGN_CHECK_EN
                    if (!is_word_aligned(npc)) begin
                        // Keep the faulting instruction's PC visible.
                        state_nxt_s = ERR_S;
                    end else begin
                        pc_nxt_s    = npc;
                        state_nxt_s = REQ_S;
                    end
`else
                    // Address taken verbatim, including low bits.
                    pc_nxt_s    = npc;
                    state_nxt_s = REQ_S;
`endif
                end else begin
                    state_nxt_s = VALID_S;
                end
            end
            ERR_S: begin
                state_nxt_s = ERR_S;
            end
            default: begin
                state_nxt_s = REQ_S;
            end
        endcase
    end

    // State, PC and instruction registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= REQ_S;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
        end else begin
            state_r <= state_nxt_s;
            pc_r    <= pc_nxt_s;
            instr_r <= instr_nxt_s;
        end
    end

    // The request is gated by rst so it stays low for the whole reset
    // window yet rises in the very first cycle after release.
    assign imem_req    = (state_r == REQ_S) && !rst;
    assign imem_addr   = pc_r;
    assign pc          = pc_r;
    assign instr       = instr_r;
    assign instr_valid = (state_r == VALID_S);

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign misalign_err = (state_r == ERR_S);
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: directed stimulus, a transaction-level
// reference model compared every cycle, plus hand-computed spot checks.
module tb_ifetch_unit;

`ifdef IFETCH_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [31:0] npc;
    logic        npc_valid;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        misalign_err;

    int checks = 0;
    int passes = 0;
    bit chk_en = 1'b0;

    ifetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .npc         (npc),
        .npc_valid   (npc_valid),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: tracks the fetch transaction, not an FSM.
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_have;     // an instruction is held for decode
    logic        m_granted;  // a request was accepted, data still due
    logic        m_err;      // a misaligned next PC was rejected

    always @(posedge clk) begin
        if (rst) begin
            m_pc <= 32'h0; m_instr <= 32'h0; m_have <= 1'b0;
            m_granted <= 1'b0; m_err <= 1'b0;
        end else if (m_err) begin
            m_err <= 1'b1;
        end else if (m_have) begin
            if (npc_valid) begin
                m_have <= 1'b0;
                if (CHK_EN && (npc % 32'd4) != 32'd0) m_err <= 1'b1;
                else m_pc <= npc;
            end
        end else if (m_granted) begin
            if (imem_rvalid) begin
                m_instr <= imem_rdata; m_have <= 1'b1; m_granted <= 1'b0;
            end
        end else if (imem_gnt) begin
            m_granted <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_req;
            exp_req = !rst && !m_granted && !m_have && !m_err;
            check("m_imem_req", {31'h0, imem_req}, {31'h0, exp_req});
            if (exp_req) check("m_imem_addr", imem_addr, m_pc);
            check("m_pc", pc, m_pc);
            check("m_instr", instr, m_instr);
            check("m_instr_valid", {31'h0, instr_valid}, {31'h0, m_have});
            check("m_misalign_err", {31'h0, misalign_err}, {31'h0, m_err});
        end
    end

    task automatic drive(input logic r, input logic nv, input logic [31:0] n,
                         input logic g, input logic rv, input logic [31:0] rd);
        rst = r; npc_valid = nv; npc = n; imem_gnt = g; imem_rvalid = rv; imem_rdata = rd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Complete one fetch from REQ_S: gnt now, rvalid next cycle.
    task automatic fetch(input logic [31:0] word);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, word); tick();
    endtask

    initial begin
        int lat;
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        chk_en = 1'b1;
        tick(); tick();
        // Reset state.
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_valid", {31'h0, instr_valid}, 32'h0);
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_err", {31'h0, misalign_err}, 32'h0);

        // First fetch: gnt in the first cycle after release.
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        check("f1_req", {31'h0, imem_req}, 32'h1);
        check("f1_addr", imem_addr, 32'h0);
        tick();
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0000_0013);
        check("f1_wait_req", {31'h0, imem_req}, 32'h0);
        tick();
        idle();
        check("f1_valid", {31'h0, instr_valid}, 32'h1);
        check("f1_instr", instr, 32'h0000_0013);
        check("f1_pc", pc, 32'h0);
        tick(); tick();
        check("f1_hold", instr, 32'h0000_0013);

        // Redirect to 0x10.
        drive(1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 32'h0);
        tick();
        idle();
        check("npc_valid_drop", {31'h0, instr_valid}, 32'h0);
        check("npc_req", {31'h0, imem_req}, 32'h1);
        check("npc_addr", imem_addr, 32'h0000_0010);
        check("npc_pc", pc, 32'h0000_0010);

        // Grant withheld 4 cycles; early rvalid and rvalid with gnt dropped.
        drive(1'b0, 1'b1, 32'h0000_0040, 1'b0, 1'b1, 32'hDEAD_0001);
        tick();
        for (int i = 0; i < 3; i++) begin
            idle(); tick();
        end
        check("stall_addr", imem_addr, 32'h0000_0010);
        check("stall_req", {31'h0, imem_req}, 32'h1);
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 32'hDEAD_0002);
        tick();
        idle(); tick();
        idle(); tick();
        check("late_novalid", {31'h0, instr_valid}, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0050_0093);
        tick();
        idle();
        check("late_valid", {31'h0, instr_valid}, 32'h1);
        check("late_instr", instr, 32'h0050_0093);

        // Minimum latency npc_valid -> instr_valid is 3 cycles.
        drive(1'b0, 1'b1, 32'h0000_0020, 1'b0, 1'b0, 32'h0);
        tick();
        lat = 1;
        fetch(32'h0000_0033);
        lat += 2;
        idle();
        check("lat_valid", {31'h0, instr_valid}, 32'h1);
        check("lat_cycles", lat, 32'd3);
        check("lat_pc", pc, 32'h0000_0020);

        // Reset while waiting for data.
        drive(1'b0, 1'b1, 32'h0000_0030, 1'b0, 1'b0, 32'h0); tick();
        drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0); tick();
        drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
        check("wrst_pc", pc, 32'h0);
        check("wrst_valid", {31'h0, instr_valid}, 32'h0);
        idle();
        check("wrst_req", {31'h0, imem_req}, 32'h1);
        check("wrst_addr", imem_addr, 32'h0);
        fetch(32'h0000_0013);

        // Misaligned next PC.
        drive(1'b0, 1'b1, 32'h0000_0006, 1'b0, 1'b0, 32'h0); tick();
        idle();
        if (CHK_EN) begin
            check("mis_err", {31'h0, misalign_err}, 32'h1);
            check("mis_pc", pc, 32'h0);
            for (int i = 0; i < 3; i++) begin
                drive(1'b0, 1'b1, 32'h0000_0008, 1'b1, 1'b1, 32'h1); tick();
            end
            idle();
            check("mis_noreq", {31'h0, imem_req}, 32'h0);
            check("mis_sticky", {31'h0, misalign_err}, 32'h1);
            drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0); tick();
            idle();
            check("mis_clear", {31'h0, misalign_err}, 32'h0);
        end else begin
            check("mis_err", {31'h0, misalign_err}, 32'h0);
            check("mis_addr", imem_addr, 32'h0000_0006);
            check("mis_req", {31'h0, imem_req}, 32'h1);
        end
        fetch(32'h0000_0077);

        // Top of the address space, then wrap to 0.
        drive(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0); tick();
        idle();
        check("top_addr", imem_addr, 32'hFFFF_FFFC);
        fetch(32'hCAFE_F00D);
        idle();
        check("top_pc", pc, 32'hFFFF_FFFC);
        check("top_instr", instr, 32'hCAFE_F00D);
        drive(1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b0, 32'h0); tick();
        idle();
        check("wrap_addr", imem_addr, 32'h0);
        fetch(32'h0000_0013);
        idle(); tick();

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
